// File: rtl/keypad_decoder.sv
// rtl/keypad_decoder.sv - PS/2 set-2 scan-code stream to held-digit vector
module keypad_decoder #(
  parameter bit ARROWS_EN      = 1'b1,
  parameter int TIMEOUT_CYCLES = 1_000_000
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic [7:0] code,
  input  logic       code_valid,
  input  logic       startOfFrame,
  input  logic       flush,
  output logic [9:0] keys,
  output logic [9:0] keys_frame,
  output logic       key_press,
  output logic [3:0] key_code
);

  localparam int            CW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t        state_q, state_d, st_eff;
  logic [CW-1:0] cnt_q;
  logic [9:0]    keys_q, keys_d, frame_q;
  logic          press_q, press_d;
  logic [3:0]    code_q, set_idx;
  logic          dig_hit, arr_hit, timed_out;
  logic [3:0]    dig_idx, arr_idx;

  assign keys       = keys_q;
  assign keys_frame = frame_q;
  assign key_press  = press_q;
  assign key_code   = code_q;

  // A pending prefix that sat idle too long is treated as if we were already back in IDLE.
  assign timed_out = (cnt_q >= TMO);
  assign st_eff    = timed_out ? IDLE : state_q;

  // Map the current byte to a digit (plain make/break) and to an arrow alias (E0-extended).
  always_comb begin
    dig_hit = 1'b1;
    dig_idx = 4'd0;
    case (code)
      8'h70:   dig_idx = 4'd0;
      8'h69:   dig_idx = 4'd1;
      8'h72:   dig_idx = 4'd2;
      8'h7A:   dig_idx = 4'd3;
      8'h6B:   dig_idx = 4'd4;
      8'h73:   dig_idx = 4'd5;
      8'h74:   dig_idx = 4'd6;
      8'h6C:   dig_idx = 4'd7;
      8'h75:   dig_idx = 4'd8;
      8'h7D:   dig_idx = 4'd9;
      default: dig_hit = 1'b0;
    endcase
    arr_hit = ARROWS_EN;
    arr_idx = 4'd0;
    case (code)
      8'h75:   arr_idx = 4'd8;
      8'h72:   arr_idx = 4'd2;
      8'h6B:   arr_idx = 4'd4;
      8'h74:   arr_idx = 4'd6;
      default: arr_hit = 1'b0;
    endcase
  end

  // Next prefix state and next held-key vector for the byte presented this cycle.
  always_comb begin
    state_d = st_eff;
    keys_d  = keys_q;
    set_idx = (st_eff == EXT) ? arr_idx : dig_idx;
    if (code_valid) begin
      case (st_eff)
        IDLE: begin
          if (code == PFX_EXT)      state_d = EXT;
          else if (code == PFX_BRK) state_d = BRK;
          else if (dig_hit)         keys_d[dig_idx] = 1'b1;
        end
        EXT: begin
          if (code == PFX_BRK)      state_d = EXT_BRK;
          else if (code == PFX_EXT) state_d = EXT;
          else begin
            state_d = IDLE;
            if (arr_hit) keys_d[arr_idx] = 1'b1;
          end
        end
        BRK: begin
          state_d = IDLE;
          if (dig_hit) keys_d[dig_idx] = 1'b0;
        end
        EXT_BRK: begin
          state_d = IDLE;
          if (arr_hit) keys_d[arr_idx] = 1'b0;
        end
        default: state_d = IDLE;
      endcase
    end
    // Only one byte per cycle, so at most one bit can rise; typematic repeats never rise.
    press_d = |(keys_d & ~keys_q);
  end

  // Register state, keys, press strobe, frame snapshot and the prefix idle counter.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      keys_q  <= '0;
      frame_q <= '0;
      press_q <= 1'b0;
      code_q  <= 4'd0;
    end else begin
      if (startOfFrame) frame_q <= keys_q;
      if (flush) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        keys_q  <= '0;
        press_q <= 1'b0;
      end else begin
        state_q <= state_d;
        keys_q  <= keys_d;
        press_q <= press_d;
        if (press_d) code_q <= set_idx;
        if (code_valid)                         cnt_q <= '0;
        else if (state_q != IDLE && !timed_out) cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// tb/tb_keypad_decoder.sv - scoreboard bench for keypad_decoder
module tb_keypad_decoder;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic [7:0] code = 8'h00;
  logic       code_valid = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       flush = 1'b0;

  logic [9:0] keys, keys_frame, keys_na, keys_frame_na;
  logic       key_press, key_press_na;
  logic [3:0] key_code, key_code_na;

  typedef struct {
    logic [3:0] c;
    logic [9:0] k;
  } exp_t;
  exp_t exp_q[$];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  keypad_decoder #(.ARROWS_EN(1'b1), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .resetN(resetN), .code(code), .code_valid(code_valid),
    .startOfFrame(startOfFrame), .flush(flush), .keys(keys),
    .keys_frame(keys_frame), .key_press(key_press), .key_code(key_code)
  );

  keypad_decoder #(.ARROWS_EN(1'b0), .TIMEOUT_CYCLES(TMO)) dut_na (
    .clk(clk), .resetN(resetN), .code(code), .code_valid(code_valid),
    .startOfFrame(startOfFrame), .flush(flush), .keys(keys_na),
    .keys_frame(keys_frame_na), .key_press(key_press_na), .key_code(key_code_na)
  );

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic expect_press(input logic [3:0] c, input logic [9:0] k);
    exp_t e;
    e.c = c;
    e.k = k;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] b);
    @(negedge clk);
    code = b;
    code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: every key_press pulse must match the next scoreboard entry.
  always @(negedge clk) begin
    if (resetN && key_press) begin
      n_chk++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_press: code %0d keys 0x%0h with empty scoreboard", key_code, keys);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (key_code !== e.c || keys !== e.k) begin
          n_fail++;
          $display("FAIL press: got code %0d keys 0x%0h expected code %0d keys 0x%0h",
                   key_code, keys, e.c, e.k);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    idle(2);
    chk("reset_keys", int'(keys), 0);
    chk("reset_frame", int'(keys_frame), 0);
    chk("reset_press", int'(key_press), 0);
    chk("reset_code", int'(key_code), 0);
    @(negedge clk);
    resetN = 1'b1;

    // Digit 8 make then break
    expect_press(4'd8, 10'h100);
    send(8'h75);
    chk("make8", int'(keys), 'h100);
    send(8'hF0);
    chk("brk_pending", int'(keys), 'h100);
    send(8'h75);
    chk("break8", int'(keys), 0);

    // Left arrow aliases to 4 only when arrows are enabled
    expect_press(4'd4, 10'h010);
    send(8'hE0);
    send(8'h6B);
    chk("left_make", int'(keys), 'h010);
    chk("left_make_na", int'(keys_na), 0);
    send(8'hE0);
    send(8'hF0);
    send(8'h6B);
    chk("left_break", int'(keys), 0);
    chk("left_break_na", int'(keys_na), 0);

    // Typematic repeat of 6 on back-to-back cycles: one press only
    expect_press(4'd6, 10'h040);
    @(negedge clk);
    code = 8'h74;
    code_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("typematic", int'(keys), 'h040);
    end
    code_valid = 1'b0;
    send(8'hF0);
    send(8'h74);
    chk("release6", int'(keys), 0);

    // Short idle after E0: prefix still pending, so F0 70 is an extended break (no effect)
    expect_press(4'd0, 10'h001);
    send(8'h70);
    send(8'hE0);
    idle(5);
    send(8'hF0);
    send(8'h70);
    chk("ext_brk_pending", int'(keys), 'h001);

    // Long idle after E0: prefix abandoned, F0 70 is a plain break
    send(8'hE0);
    idle(TMO + 4);
    send(8'hF0);
    send(8'h70);
    chk("timeout_break", int'(keys), 0);

    // Timeout then 72 is digit 2, visible even without arrow aliasing
    send(8'hE0);
    idle(TMO + 4);
    expect_press(4'd2, 10'h004);
    send(8'h72);
    chk("timeout_72", int'(keys), 'h004);
    chk("timeout_72_na", int'(keys_na), 'h004);
    send(8'hF0);
    send(8'h72);

    // Hold 6 and 8, then flush collides with a 70 make
    expect_press(4'd6, 10'h040);
    send(8'h74);
    expect_press(4'd8, 10'h140);
    send(8'h75);
    chk("hold68", int'(keys), 'h140);
    @(negedge clk);
    flush = 1'b1;
    code = 8'h70;
    code_valid = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    code_valid = 1'b0;
    chk("flush_keys", int'(keys), 0);
    chk("flush_press", int'(key_press), 0);

    // Frame snapshot: 5 pressed two cycles before the pulse
    expect_press(4'd5, 10'h020);
    send(8'h73);
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    chk("frame5", int'(keys_frame), 'h020);
    // 3 completes in the same cycle as the pulse: only the next pulse shows it
    expect_press(4'd3, 10'h028);
    @(negedge clk);
    code = 8'h7A;
    code_valid = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    startOfFrame = 1'b0;
    chk("frame_same_cycle", int'(keys_frame), 'h020);
    chk("keys_53", int'(keys), 'h028);
    idle(2);
    chk("frame_hold", int'(keys_frame), 'h020);
    @(negedge clk);
    startOfFrame = 1'b1;
    @(negedge clk);
    startOfFrame = 1'b0;
    chk("frame_next", int'(keys_frame), 'h028);

    // Reset in the middle of an E0 F0 prefix
    send(8'hE0);
    send(8'hF0);
    #2;
    resetN = 1'b0;
    #1;
    chk("rst_keys", int'(keys), 0);
    chk("rst_frame", int'(keys_frame), 0);
    chk("rst_code", int'(key_code), 0);
    @(negedge clk);
    resetN = 1'b1;
    expect_press(4'd1, 10'h002);
    send(8'h69);
    chk("after_rst", int'(keys), 'h002);

    idle(3);
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/keypad_decoder.md
# keypad_decoder

Converts the PS/2 scan-code byte stream (set 2) from the keyboard byte receiver into the 10-bit held-key vector that the character movement and game-control blocks consume as `num_input`. Tracks make/break and E0-extended prefixes, so a bit stays high for as long as its key is physically held. Also provides a frame-stable copy of the vector and a one-cycle new-press strobe. Sits between the PS/2 receiver and every block that reads keypad digits.

## Interface
- `ARROWS_EN`, default 1: when 1, extended arrow keys alias to digits (up→8, down→2, left→4, right→6).
- `TIMEOUT_CYCLES`, default 1_000_000: maximum idle cycles allowed while a prefix is pending; on expiry the decoder abandons the prefix.
- `clk` in, 1: system clock, single clock domain.
- `resetN` in, 1: asynchronous, active-low reset.
- `code` in, 8: scan-code byte from the PS/2 receiver; valid only when `code_valid` is high.
- `code_valid` in, 1: one-cycle strobe per received byte.
- `startOfFrame` in, 1: one-cycle pulse per video frame.
- `flush` in, 1: synchronous clear of all held keys (game over / level change).
- `keys` out, 10: live held-key vector; bit n means digit n is held.
- `keys_frame` out, 10: `keys` sampled on `startOfFrame`.
- `key_press` out, 1: one-cycle pulse when a bit of `keys` rises 0→1.
- `key_code` out, 4: index of the most recent newly pressed digit.

## Operation
- Digit make codes: 0=70, 1=69, 2=72, 3=7A, 4=6B, 5=73, 6=74, 7=6C, 8=75, 9=7D (hex).
- Extended arrow codes: E0 75 up, E0 72 down, E0 6B left, E0 74 right.
- FSM states: IDLE, EXT (E0 received), BRK (F0 received), EXT_BRK (E0 F0 received).
- IDLE:
  - E0 → EXT.
  - F0 → BRK.
  - Mapped digit → set its bit; stay in IDLE.
  - Any other byte → ignored.
- EXT:
  - F0 → EXT_BRK.
  - E0 → stay in EXT.
  - Arrow code with `ARROWS_EN`=1 → set the aliased bit, go to IDLE.
  - Anything else → IDLE, no change.
- BRK: mapped digit → clear its bit. Any byte → IDLE.
- EXT_BRK: arrow code with `ARROWS_EN`=1 → clear the aliased bit. Any byte → IDLE.
- Typematic repeat (make code for a key already held): `keys` is unchanged and no `key_press` is generated.
- `key_press` and `key_code` update only on a 0→1 transition of a bit. Because only one byte is processed per cycle, at most one bit rises per cycle.
- Timeout counter:
  - Clears on every `code_valid`.
  - Counts while the state is not IDLE; saturates at `TIMEOUT_CYCLES`.
  - On reaching `TIMEOUT_CYCLES`: state → IDLE; `keys` is untouched.
- `flush`:
  - Clears `keys`, state → IDLE, counter → 0.
  - If `flush` and `code_valid` occur in the same cycle, `flush` wins and the byte is dropped.
- Left and right, or up and down, may both be held at once. The decoder reports both; priority is resolved by the consumer.

## Timing
- Reset values: `keys`=0, `keys_frame`=0, `key_press`=0, `key_code`=0, state IDLE, counter 0.
- `keys` changes on the clock edge after the `code_valid` that completes a sequence (1-cycle latency). `key_press` is high in the same cycle that the new `keys` value is visible.
- `keys_frame` loads `keys` (the registered value, not the next value) on the edge where `startOfFrame`=1. It holds otherwise.
- A byte that completes a sequence in the same cycle as `startOfFrame` does not reach `keys_frame` until the next frame.
- Reset asserted mid-sequence returns everything to the reset values immediately. A partial prefix is discarded.
- `code_valid` may arrive on consecutive cycles; the decoder accepts one byte per cycle with no back-pressure.

## Test plan
- Bytes 75; then F0 75 → `keys`=0x100 one cycle after 75, with `key_press`=1 and `key_code`=8. `keys`=0 one cycle after the final 75.
- Bytes E0 6B; then E0 F0 6B with `ARROWS_EN`=1 → bit 4 set, then cleared. Repeat with `ARROWS_EN`=0 → `keys` stays 0.
- Bytes 74 74 74 (typematic) → exactly one `key_press` pulse, and `keys`=0x040 throughout.
- Byte E0, then no byte for `TIMEOUT_CYCLES`, then 72 → state returns to IDLE. 72 is treated as digit 2 (`keys`=0x004), not as an arrow.
- Hold 6 and 8 (`keys`=0x140), then assert `flush` in the same cycle as `code_valid` with 70 → `keys`=0 and no `key_press`.
- Press 5 two cycles before `startOfFrame` → `keys_frame`=0x020 after that frame pulse. Press 3 in the same cycle as `startOfFrame` → `keys_frame` shows bit 3 only after the next pulse.
